// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV64M multiply/divide unit
// Multi-cycle M-extension unit that sits beside the ALU in execute.
// Multiply is shift-add, one multiplier bit per cycle. Divide is restoring,
// one quotient bit per cycle. Divide by zero and MIN/-1 are resolved when
// the operation is accepted and skip the iteration entirely.
// Optional build macro: MULDIV_FAST_MUL_EN (multiplies complete in one cycle
// through a combinational multiplier; divide unchanged).
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled on clk
//   ir     - M-extension instruction word (OP or OP-32)
//   a, b   - rs1 / rs2 operands, captured with an accepted start
//   busy   - operation in progress, starts ignored
//   done   - one-cycle pulse, result valid from this cycle
//   result - registered result, held until the next done
module muldiv #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [31:0]     ir,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_nx;

   // Iteration state. p holds {high, low}: for multiply {partial product,
   // remaining multiplier bits}, for divide {partial remainder, dividend
   // bits not yet consumed / quotient bits shifted in}.
   logic [2*XLEN-1:0] p;
   logic [XLEN-1:0]   opnd;
   logic [CW-1:0]     cnt;
   logic [2:0]        f3_q;
   logic              w_q;
   logic              neg_q;

   // ---------------- decode ----------------
   logic [6:0] opcode;
   logic [2:0] f3;
   logic       is_op, is_w, legal, accept, bypass;
   logic       unused_ir;

   assign opcode    = ir[6:0];
   assign f3        = ir[14:12];
   assign is_op     = (opcode == 7'b0110011);
   assign is_w      = (XLEN == 64) && (opcode == 7'b0111011);
   assign legal     = (ir[31:25] == 7'b0000001) &&
                      (is_op || (is_w && ((f3 == 3'b000) || f3[2])));
   assign unused_ir = ^{ir[24:15], ir[11:7]};

   // Accept is derived from state rather than busy so the FSM process has
   // no combinational path through its own outputs.
   assign accept = start && legal && ((state == S_IDLE) || (state == S_DONE));

   // ---------------- helpers ----------------
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // prod is the magnitude product aligned at bit 0 (W products included).
   function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] prod,
                                                input logic neg,
                                                input logic [2:0] fn,
                                                input logic w);
      logic [2*XLEN-1:0] full;
      logic [XLEN-1:0]   r;
      full = neg ? -prod : prod;
      if (w)
         r = sext32(full[31:0]);
      else if (fn == 3'b000)
         r = full[XLEN-1:0];
      else
         r = full[2*XLEN-1:XLEN];
      return r;
   endfunction

   function automatic logic [XLEN-1:0] div_fix(input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] rem,
                                                input logic neg,
                                                input logic [2:0] fn,
                                                input logic w);
      logic [XLEN-1:0] v;
      logic [31:0]     v32;
      logic [XLEN-1:0] r;
      v = fn[1] ? rem : q;
      if (w) begin
         v32 = neg ? -v[31:0] : v[31:0];
         r   = sext32(v32);
      end else begin
         r = neg ? -v : v;
      end
      return r;
   endfunction

   // ---------------- operand magnitudes and result sign ----------------
   logic            a_sgn, b_sgn, a_neg, b_neg, neg_res;
   logic [XLEN-1:0] a_mag, b_mag, dividend;

   assign a_sgn   = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
   assign b_sgn   = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
   assign a_neg   = a_sgn && (is_w ? a[31] : a[XLEN-1]);
   assign b_neg   = b_sgn && (is_w ? b[31] : b[XLEN-1]);
   // REM takes the dividend's sign; everything else the product of signs.
   assign neg_res = (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);

   always_comb begin
      a_mag = '0;
      b_mag = '0;
      if (is_w) begin
         a_mag[31:0] = a_neg ? -a[31:0] : a[31:0];
         b_mag[31:0] = b_neg ? -b[31:0] : b[31:0];
      end else begin
         a_mag = a_neg ? -a : a;
         b_mag = b_neg ? -b : b;
      end
   end

   // A W dividend starts at the top of the low half so that 32 shifts
   // leave the quotient in bits [31:0].
   assign dividend = is_w ? (a_mag << (XLEN - 32)) : a_mag;

   // ---------------- divide corner cases ----------------
   logic            b_zero, ovf, div_special;
   logic [XLEN-1:0] a_ext, special_val, bypass_val;

   assign b_zero      = is_w ? (b[31:0] == 32'h0) : (b == '0);
   assign ovf         = ((f3 == 3'b100) || (f3 == 3'b110)) &&
                        (is_w ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                              : ((a == MIN_NEG) && (b == '1)));
   assign a_ext       = is_w ? sext32(a[31:0]) : a;
   assign div_special = f3[2] && (b_zero || ovf);

   always_comb begin
      special_val = '0;
      if (b_zero)
         special_val = f3[1] ? a_ext : '1;
      else
         special_val = f3[1] ? '0 : a_ext;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
   assign bypass     = div_special || !f3[2];
   assign bypass_val = f3[2] ? special_val : mul_fix(fast_prod, neg_res, f3, is_w);
`else
   assign bypass     = div_special;
   assign bypass_val = special_val;
`endif

   // ---------------- one iteration step ----------------
   logic [XLEN:0]     mul_sum, div_t, div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_next, div_next, mul_aligned;
   logic [XLEN-1:0]   fix_val;

   assign mul_sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, p[XLEN-1:1]};

   assign div_t    = {p[2*XLEN-1:XLEN], p[XLEN-1]};
   assign div_ge   = (div_t >= {1'b0, opnd});
   assign div_diff = div_t - {1'b0, opnd};
   assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0]), p[XLEN-2:0], div_ge};

   // After only 32 steps a W product still sits XLEN-32 bits up.
   assign mul_aligned = w_q ? (p >> (XLEN - 32)) : p;
   assign fix_val     = f3_q[2] ? div_fix(p[XLEN-1:0], p[2*XLEN-1:XLEN], neg_q, f3_q, w_q)
                                : mul_fix(mul_aligned, neg_q, f3_q, w_q);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept)
               state_nx = bypass ? S_DONE : S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (cnt == '0)
               state_nx = S_FIX;
         end
         S_FIX: begin
            busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (accept)
               state_nx = bypass ? S_DONE : S_CALC;
            else
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p      <= '0;
         opnd   <= '0;
         cnt    <= '0;
         f3_q   <= '0;
         w_q    <= 1'b0;
         neg_q  <= 1'b0;
         result <= '0;
      end else if (accept) begin
         f3_q  <= f3;
         w_q   <= is_w;
         neg_q <= neg_res;
         cnt   <= is_w ? CW'(31) : CW'(XLEN - 1);
         if (f3[2]) begin
            opnd <= b_mag;
            p    <= {{XLEN{1'b0}}, dividend};
         end else begin
            opnd <= a_mag;
            p    <= {{XLEN{1'b0}}, b_mag};
         end
         if (bypass)
            result <= bypass_val;
      end else if (state == S_CALC) begin
         p   <= f3_q[2] ? div_next : mul_next;
         cnt <= cnt - CW'(1);
      end else if (state == S_FIX) begin
         result <= fix_val;
      end
   end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized and directed bench for muldiv against a reference model
module tb_muldiv;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int MLAT  = FAST ? 1 : 66;
   localparam int MWLAT = FAST ? 1 : 34;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic [31:0] ir    = '0;
   logic [63:0] a     = '0;
   logic [63:0] b     = '0;
   logic        busy, done;
   logic [63:0] result;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   muldiv #(.XLEN(64)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .ir     (ir),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit legal(input logic [31:0] i);
      logic [2:0] f;
      f = i[14:12];
      return (i[31:25] == 7'h01) &&
             ((i[6:0] == 7'h33) ||
              ((i[6:0] == 7'h3B) && (f == 3'd0 || f == 3'd4 || f == 3'd5 || f == 3'd6 || f == 3'd7)));
   endfunction

   function automatic int op_latency(input logic [2:0] f, input bit w, input logic [63:0] x, input logic [63:0] y);
      bit sdiv, special;
      sdiv = (f == 3'd4) || (f == 3'd6);
      if (f[2]) begin
         if (w)
            special = (y[31:0] == 32'h0) ||
                      (sdiv && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
         else
            special = (y == 64'h0) || (sdiv && x == MIN64 && y == '1);
         if (special) return 1;
         return w ? 34 : 66;
      end
      if (FAST) return 1;
      return w ? 34 : 66;
   endfunction

   function automatic logic [63:0] ref_res(input logic [2:0] f, input bit w, input logic [63:0] x, input logic [63:0] y);
      logic signed [127:0] pa, pb, pr;
      logic [127:0]        ua, ub, up;
      logic signed [63:0]  sx, sy;
      logic signed [31:0]  sx32, sy32;
      logic [31:0]         x32, y32, r32;
      logic [63:0]         r;
      r = '0;
      if (w) begin
         x32 = x[31:0]; y32 = y[31:0];
         sx32 = x32;    sy32 = y32;
         r32 = '0;
         case (f)
            3'd0: r32 = x32 * y32;
            3'd4: begin
               if (y32 == 0) r32 = '1;
               else if (x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) r32 = x32;
               else r32 = sx32 / sy32;
            end
            3'd5: begin
               if (y32 == 0) r32 = '1;
               else r32 = x32 / y32;
            end
            3'd6: begin
               if (y32 == 0) r32 = x32;
               else if (x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) r32 = '0;
               else r32 = sx32 % sy32;
            end
            3'd7: begin
               if (y32 == 0) r32 = x32;
               else r32 = x32 % y32;
            end
            default: r32 = '0;
         endcase
         return {{32{r32[31]}}, r32};
      end
      sx = x; sy = y;
      case (f)
         3'd0: r = x * y;
         3'd1: begin pa = sx; pb = sy; pr = pa * pb; r = pr[127:64]; end
         3'd2: begin pa = sx; pb = {64'h0, y}; pr = pa * pb; r = pr[127:64]; end
         3'd3: begin ua = {64'h0, x}; ub = {64'h0, y}; up = ua * ub; r = up[127:64]; end
         3'd4: begin
            if (y == 0) r = '1;
            else if (x == MIN64 && y == '1) r = x;
            else r = sx / sy;
         end
         3'd5: begin
            if (y == 0) r = '1;
            else r = x / y;
         end
         3'd6: begin
            if (y == 0) r = x;
            else if (x == MIN64 && y == '1) r = '0;
            else r = sx % sy;
         end
         default: begin
            if (y == 0) r = x;
            else r = x % y;
         end
      endcase
      return r;
   endfunction

   // Expected outputs for the cycle after each edge: an accepted op finishes
   // after its latency, the unit is busy until then, result updates on done.
   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [63:0] m_result = '0, m_pend = '0;
   int          m_left = 0;
   logic        nb, nd;
   logic [63:0] nr, np, mv;
   int          nl, ml;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_result <= '0;
         m_pend   <= '0;
         m_left   <= 0;
      end else begin
         nb = m_busy; nl = m_left; nd = 1'b0; nr = m_result; np = m_pend;
         if (nb) begin
            nl = nl - 1;
            if (nl == 0) begin nd = 1'b1; nr = np; nb = 1'b0; end
         end
         if (start && !m_busy && legal(ir)) begin
            ml = op_latency(ir[14:12], ir[6:0] == 7'h3B, a, b);
            mv = ref_res(ir[14:12], ir[6:0] == 7'h3B, a, b);
            if (ml == 1) begin nd = 1'b1; nr = mv; end
            else begin nb = 1'b1; nl = ml - 1; np = mv; end
         end
         m_busy   <= nb;
         m_left   <= nl;
         m_done   <= nd;
         m_result <= nr;
         m_pend   <= np;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle busy",   64'(busy), 64'(m_busy));
         check("cycle done",   64'(done), 64'(m_done));
         check("cycle result", result,    m_result);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] mk_ir(input logic [2:0] f, input bit w, input logic [6:0] f7);
      return {f7, 5'($urandom), 5'($urandom), f, 5'($urandom), (w ? 7'h3B : 7'h33)};
   endfunction

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 64'h0;
         1: return '1;
         2: return MIN64;
         3: return 64'h0000_0000_8000_0000;
         4: return 64'($urandom_range(0, 40));
         5: return -64'($urandom_range(1, 40));
         6: return {32'($urandom), 32'hFFFF_FFFF};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   task automatic run_op(input string name, input logic [2:0] f, input bit w,
                         input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] exp, input int exp_lat, input bit nowait);
      int lat, busy_n;
      if (!nowait) @(negedge clk);
      ir = mk_ir(f, w, 7'h01); a = av; b = bv; start = 1'b1;
      lat = 0; busy_n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) busy_n++;
      end while (!done && lat < 200);
      check({name, " result"},  result,       exp);
      check({name, " latency"}, 64'(lat),     64'(exp_lat));
      check({name, " busy"},    64'(busy_n),  64'(exp_lat > 1 ? exp_lat - 1 : 0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int g;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset busy",   64'(busy), 64'd0);
      check("reset done",   64'(done), 64'd0);
      check("reset result", result,    64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      check("model mulh", ref_res(3'd1, 1'b0, MIN64, MIN64), 64'h4000_0000_0000_0000);
      check("model div",  ref_res(3'd4, 1'b0, -64'd20, 64'd6), 64'hFFFF_FFFF_FFFF_FFFD);
      check("model remw", ref_res(3'd6, 1'b1, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);

      run_op("mul",    3'd0, 1'b0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, MLAT, 1'b0);
      run_op("mulh",   3'd1, 1'b0, MIN64, MIN64,  64'h4000_0000_0000_0000, MLAT, 1'b0);
      run_op("mulhu",  3'd3, 1'b0, MIN64, MIN64,  64'h4000_0000_0000_0000, MLAT, 1'b0);
      run_op("mulhsu", 3'd2, 1'b0, MIN64, MIN64,  64'hC000_0000_0000_0000, MLAT, 1'b0);
      run_op("div",    3'd4, 1'b0, -64'd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0);
      run_op("rem",    3'd6, 1'b0, -64'd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b0);
      run_op("divu0",  3'd5, 1'b0, 64'd5, 64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      run_op("rem0",   3'd6, 1'b0, 64'd5, 64'd0,  64'd5, 1, 1'b0);
      run_op("divovf", 3'd4, 1'b0, MIN64, '1,     MIN64, 1, 1'b0);
      run_op("divw",   3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
      run_op("mulw",   3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MWLAT, 1'b0);

      run_op("b2b div", 3'd4, 1'b0, -64'd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0);
      run_op("b2b rem", 3'd6, 1'b0, -64'd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b1);

      // A start while busy must not disturb the running divide.
      @(negedge clk);
      ir = mk_ir(3'd4, 1'b0, 7'h01); a = -64'd20; b = 64'd6; start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (lat == 5) begin
            ir = mk_ir(3'd5, 1'b0, 7'h01); a = 64'd5; b = 64'd0; start = 1'b1;
         end
      end while (!done && lat < 200);
      check("ignored start result",  result,   64'hFFFF_FFFF_FFFF_FFFD);
      check("ignored start latency", 64'(lat), 64'd66);
      @(negedge clk);
      check("done single cycle", 64'(done), 64'd0);

      // Reset in the middle of a divide.
      ir = mk_ir(3'd4, 1'b0, 7'h01); a = -64'd20; b = 64'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("midop busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("midop reset busy",   64'(busy), 64'd0);
      check("midop reset done",   64'(done), 64'd0);
      check("midop reset result", result,    64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic including illegal words and starts while busy.
      for (int i = 0; i < 60; i++) begin
         logic [2:0] rf;
         logic       rw;
         logic [6:0] rf7;
         rf  = 3'($urandom);
         rw  = 1'($urandom);
         rf7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h01;
         ir = mk_ir(rf, rw, rf7); a = rnd_op(); b = rnd_op(); start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            repeat (3) @(negedge clk);
            ir = mk_ir(3'($urandom), 1'($urandom), 7'h01); a = rnd_op(); b = rnd_op(); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         g = 0;
         while (m_busy && g < 200) begin
            @(negedge clk);
            g++;
         end
         check("random wait bound", 64'(g < 200), 64'd1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
